mult_result_axis_fifo: RTL and testbench
========================================

MULT_RESULT_AXIS_FIFO -- requirements
Module: mult_result_axis_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries; legal values are powers of two from 2 to 64.
REQ-002 SHALL have parameter PKT_LEN, default 16, meaning beats per AXI-Stream packet; legal range is 1 to 65535.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port data_valid_i, input, 1 bit: multiplier result strobe.
REQ-006 SHALL have port product_i, input, 32 bits: multiplier product16x16 result.
REQ-007 SHALL have port m_axis_valid_o, output, 1 bit: AXI-Stream master TVALID.
REQ-008 SHALL have port m_axis_data_o, output, 32 bits: AXI-Stream master TDATA.
REQ-009 SHALL have port m_axis_last_o, output, 1 bit: AXI-Stream master TLAST.
REQ-010 SHALL have port m_axis_ready_i, input, 1 bit: AXI-Stream TREADY from the DMA.
REQ-011 SHALL have port level_o, output, clog2(DEPTH)+1 bits: current occupancy.
REQ-012 SHALL have port overflow_o, output, 1 bit: sticky flag set when a result was dropped.

Function
REQ-013 SHALL push product_i when data_valid_i=1 and the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-014 SHALL pop when m_axis_valid_o=1 and m_axis_ready_i=1.
REQ-015 SHALL drive m_axis_valid_o = (level != 0) and m_axis_data_o = the entry at the read pointer.
REQ-016 SHALL NOT fall through: a push into an empty FIFO at edge N makes m_axis_valid_o=1 after edge N, giving 1-cycle latency.
REQ-017 SHALL hold m_axis_data_o and m_axis_last_o stable while m_axis_valid_o=1 and m_axis_ready_i=0.
REQ-018 SHALL, on simultaneous push and pop, leave level unchanged and advance both pointers.
REQ-019 SHALL wrap read and write pointers modulo DEPTH with no bubble.
REQ-020 SHALL, on push while full with no pop, discard the data, set overflow_o=1, and leave level and pointers unchanged.
REQ-021 SHALL clear overflow_o only by reset.
REQ-022 SHALL, on pop while empty, do nothing; this case is unreachable because valid=0.
REQ-023 SHALL keep level_o in the range 0..DEPTH at all times, with full defined as level_o==DEPTH.

Reset
REQ-024 SHALL, while reset_i=1 at a clock edge, clear pointers, level_o, overflow_o and the beat counter.
REQ-025 SHALL drive m_axis_valid_o=0, m_axis_last_o=0 and level_o=0 after reset; m_axis_data_o is don't-care while valid=0.
REQ-026 SHALL, on reset asserted mid-packet or mid-transfer, discard all stored entries and start the next packet at beat 0.
REQ-027 SHALL ignore data_valid_i in any cycle where reset_i=1.

Configuration
REQ-028 SHALL, with MULT_RESULT_FIFO_TLAST_EN defined, use a beat counter 0..PKT_LEN-1 that increments on each pop and wraps to 0 after PKT_LEN-1.
REQ-029 SHALL, with MULT_RESULT_FIFO_TLAST_EN defined, assert m_axis_last_o = valid && (beat counter == PKT_LEN-1).
REQ-030 SHALL, without MULT_RESULT_FIFO_TLAST_EN, tie m_axis_last_o to 0 and synthesize no beat counter; all other behaviour is identical.

Verification
REQ-031 Bench SHALL cover: reset, then push 0x00010002 with ready=1 -> valid=1 exactly one cycle later with data 0x00010002, and level returns 0 after the pop.
REQ-032 Bench SHALL cover: ready=0, push 8 results 0x0..0x7 (DEPTH=8), then a 9th 0xFF -> level_o=8, overflow_o=1; ready=1 drains 0x0..0x7 in order and 0xFF never appears.
REQ-033 Bench SHALL cover: full FIFO with ready=1 and push 0xAA in the same cycle -> level stays 8, and 0xAA emerges 8th after the existing entries with overflow_o still 0.
REQ-034 Bench SHALL cover: TLAST_EN, PKT_LEN=4, 10 results streamed with random ready -> last=1 on beats 3 and 7 only; the counter holds when ready=0.
REQ-035 Bench SHALL cover: 3 entries stored, ready=0, reset_i pulsed for 1 cycle -> valid=0, level_o=0, overflow_o=0; the next push's pop is beat 0 of a packet.
REQ-036 Bench SHALL cover: 1000 random pushes and random ready -> output sequence equals the pushed sequence minus the dropped entries, and overflow_o matches the drop events.

Source files
------------

// File: rtl/mult_result_axis_fifo.sv
// mult_result_axis_fifo
//
// Buffers 32-bit multiplier results and presents them as an AXI-Stream master
// towards a DMA. The FIFO is non-fall-through: a result written at edge N is
// visible on the stream after edge N. A write arriving while the FIFO is full
// is dropped unless a read happens in the same cycle, and any drop sets a
// sticky overflow flag that only reset clears.
//
// Optional feature (define MULT_RESULT_FIFO_TLAST_EN):
//   A beat counter groups popped beats into PKT_LEN-beat packets and raises
//   m_axis_last_o on the final beat. Without the macro m_axis_last_o is 0 and
//   no counter exists.
//
// Parameters:
//   DEPTH   - FIFO entries, power of two in 2..64
//   PKT_LEN - beats per packet, 1..65535 (used only with TLAST enabled)
//
// Ports:
//   clk_i          - clock, rising edge
//   reset_i        - synchronous active-high reset
//   data_valid_i   - multiplier result strobe
//   product_i      - multiplier result
//   m_axis_valid_o - TVALID, high while the FIFO holds data
//   m_axis_data_o  - TDATA, entry at the read pointer
//   m_axis_last_o  - TLAST
//   m_axis_ready_i - TREADY from the DMA
//   level_o        - occupancy, 0..DEPTH
//   overflow_o     - sticky drop flag
module mult_result_axis_fifo #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned PKT_LEN = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       data_valid_i,
    input  logic [31:0]                product_i,
    output logic                       m_axis_valid_o,
    output logic [31:0]                m_axis_data_o,
    output logic                       m_axis_last_o,
    input  logic                       m_axis_ready_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;

    logic empty, full, push, pop, drop;

    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));
    assign pop   = !empty && m_axis_ready_i;
    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    assign push  = data_valid_i && (!full || pop);
    assign drop  = data_valid_i && full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q | drop;
        // DEPTH is a power of two, so plain increment wraps the pointers.
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (!reset_i && push) begin
            mem_q[wr_ptr_q] <= product_i;
        end
    end

    assign m_axis_valid_o = !empty;
    assign m_axis_data_o  = mem_q[rd_ptr_q];
    assign level_o        = level_q;
    assign overflow_o     = overflow_q;

`ifdef MULT_RESULT_FIFO_TLAST_EN
    logic [15:0] beat_q, beat_d;
    logic        last_beat;

    assign last_beat = (beat_q == 16'(PKT_LEN - 1));

    // Counts accepted beats only, so it holds while the DMA stalls.
    always_comb begin
        beat_d = beat_q;
        if (pop) begin
            beat_d = last_beat ? 16'd0 : beat_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

    assign m_axis_last_o = !empty && last_beat;
`else
    assign m_axis_last_o = 1'b0;
`endif

endmodule

// File: tb/tb_mult_result_axis_fifo.sv
// Self-checking bench for mult_result_axis_fifo (DEPTH=8, PKT_LEN=4).
// A queue of expected entries is filled as results are offered and drained as
// the DUT hands beats to the stream; level, overflow and TLAST are predicted
// from the same queue and a beat counter.
module tb_mult_result_axis_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned PKT   = 4;
`ifdef MULT_RESULT_FIFO_TLAST_EN
    localparam bit TLAST_EN = 1'b1;
`else
    localparam bit TLAST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        data_valid_i = 1'b0;
    logic [31:0] product_i = '0;
    logic        m_axis_valid_o;
    logic [31:0] m_axis_data_o;
    logic        m_axis_last_o;
    logic        m_axis_ready_i = 1'b0;
    logic [3:0]  level_o;
    logic        overflow_o;

    mult_result_axis_fifo #(.DEPTH(DEPTH), .PKT_LEN(PKT)) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .data_valid_i   (data_valid_i),
        .product_i      (product_i),
        .m_axis_valid_o (m_axis_valid_o),
        .m_axis_data_o  (m_axis_data_o),
        .m_axis_last_o  (m_axis_last_o),
        .m_axis_ready_i (m_axis_ready_i),
        .level_o        (level_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk = ~clk;

    logic [31:0] q[$];
    bit          movf;
    int unsigned mbeat;
    int          nt = 0;
    int          nf = 0;
    int          nlast = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nt++;
        assert (obs === exp) else begin
            nf++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check current outputs, advance, update the model.
    task automatic cyc(input bit dv, input logic [31:0] d, input bit rdy);
        bit mpop, mpush, mdrop;
        data_valid_i   = dv;
        product_i      = d;
        m_axis_ready_i = rdy;
        #1;
        chk("valid", m_axis_valid_o, q.size() != 0);
        chk("last", m_axis_last_o, TLAST_EN && q.size() != 0 && mbeat == PKT - 1);
        if (q.size() != 0) chk("data", m_axis_data_o, q[0]);
        mpop  = (q.size() != 0) && rdy;
        mpush = dv && ((q.size() < DEPTH) || mpop);
        mdrop = dv && !mpush;
        if (mpop && m_axis_last_o) nlast++;
        tick();
        if (mpop) begin
            void'(q.pop_front());
            mbeat = (mbeat == PKT - 1) ? 0 : mbeat + 1;
        end
        if (mpush) q.push_back(d);
        if (mdrop) movf = 1'b1;
        chk("level", level_o, q.size());
        chk("overflow", overflow_o, movf);
    endtask

    task automatic rst(input bit dv);
        reset_i        = 1'b1;
        data_valid_i   = dv;
        product_i      = 32'hDEAD_BEEF;
        m_axis_ready_i = 1'b0;
        tick();
        reset_i      = 1'b0;
        data_valid_i = 1'b0;
        q.delete();
        movf  = 1'b0;
        mbeat = 0;
        chk("rst_valid", m_axis_valid_o, 0);
        chk("rst_last", m_axis_last_o, 0);
        chk("rst_level", level_o, 0);
        chk("rst_overflow", overflow_o, 0);
    endtask

    task automatic drain(input bit random_ready);
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            cyc(1'b0, '0, random_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        rst(1'b0);
        rst(1'b1);

        // Single result: visible one cycle after the push, gone after the pop.
        cyc(1'b1, 32'h0001_0002, 1'b1);
        chk("lat_valid", m_axis_valid_o, 1);
        chk("lat_data", m_axis_data_o, 32'h0001_0002);
        cyc(1'b0, '0, 1'b1);
        chk("lat_level0", level_o, 0);

        // Fill, then overflow with 0xFF which must never come out.
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'(i), 1'b0);
        cyc(1'b1, 32'hFF, 1'b0);
        chk("full_level", level_o, 8);
        chk("full_ovf", overflow_o, 1);
        drain(1'b0);

        // Full FIFO with simultaneous pop and push: no drop, 0xAA comes out 8th.
        rst(1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'h10 + 32'(i), 1'b0);
        cyc(1'b1, 32'hAA, 1'b1);
        chk("pp_level", level_o, 8);
        chk("pp_ovf", overflow_o, 0);
        chk("pp_tail", q[7], 32'hAA);
        drain(1'b0);
        chk("pp_ovf_after", overflow_o, 0);

        // Reset mid-packet with entries stored; counter restarts at beat 0.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h30 + 32'(i), 1'b0);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b0);
        rst(1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h40 + 32'(i), 1'b1);
        drain(1'b0);

        // Packets of 4 with random back-pressure; last on beats 3 and 7 only.
        rst(1'b0);
        nlast = 0;
        for (int i = 0; i < 10; i++) cyc(1'b1, 32'h100 + 32'(i), 1'($urandom_range(0, 1)));
        drain(1'b1);
        chk("pkt_last_count", nlast, TLAST_EN ? 2 : 0);

        // Long random run against the scoreboard, including drops.
        rst(1'b0);
        for (int i = 0; i < 1000; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) == 0));
        end
        drain(1'b1);

        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
